// File: rtl/cycler_seek_ctrl.sv
// Seek sequencer for a blind up/down ring counter: walks the cycler to a target by the
// shortest path and cross-checks every step against a shadow position.
module cycler_seek_ctrl #(
  parameter int WIDTH       = 3,
  parameter int SETUP       = 2,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_target_i,
  input  logic [WIDTH-1:0] cyc_num_i,
  output logic             cyc_dir_o,
  output logic             cyc_nxt_o,
  output logic [WIDTH-1:0] pos_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CMAX = (SETUP > HALF_PERIOD) ? SETUP : HALF_PERIOD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0]    SETUP_LAST = CW'(SETUP - 1);
  localparam logic [CW-1:0]    HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [WIDTH-1:0] HALF_RING  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] up;
  logic [WIDTH-1:0] pos_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      pos_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    err_d    = err_q;
    up       = tgt_q - pos_q;
    pos_step = dir_q ? (pos_q - WIDTH'(1)) : (pos_q + WIDTH'(1));
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_CALC;
          tgt_d   = req_target_i;
          pos_d   = cyc_num_i;
          err_d   = 1'b0;
        end
      end
      S_CALC: begin
        // Exactly half-way round counts as "up" so ties are deterministic.
        if (up <= HALF_RING) begin
          dir_d = 1'b0;
          rem_d = up;
        end else begin
          dir_d = 1'b1;
          rem_d = WIDTH'(0) - up;
        end
        cnt_d   = '0;
        state_d = (up == '0) ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          pos_d   = pos_step;
          rem_d   = rem_q - WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == HALF_LAST) begin
          // The cycler has had a full low half-period to settle before we trust it.
          if (cyc_num_i != pos_q) err_d = 1'b1;
          cnt_d = '0;
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HIGH;
            pos_d   = pos_step;
            rem_d   = rem_q - WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign cyc_nxt_o   = (state_q == S_HIGH);
  assign cyc_dir_o   = dir_q;
  assign pos_o       = pos_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cycler_seek_ctrl.sv
// Directed bench for cycler_seek_ctrl with a behavioural ring-counter cycler model.
module tb_cycler_seek_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_target = 3'd0;
  logic [2:0] cyc_num;
  logic       req_ready, cyc_dir, cyc_nxt, busy, done, err;
  logic [2:0] pos;

  logic [2:0] ring;
  logic [2:0] set_val = 3'd0;
  logic [2:0] hold_val = 3'd0;
  logic       set_stb = 1'b0;
  logic       hold = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Cycler: advances on rising nxt; the bench can preload it or force a stuck value.
  always @(posedge cyc_nxt or posedge set_stb)
    if (set_stb) ring <= set_val;
    else         ring <= cyc_dir ? ring - 3'd1 : ring + 3'd1;
  assign cyc_num = hold ? hold_val : ring;

  cycler_seek_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_target_i(req_target),
    .cyc_num_i(cyc_num), .cyc_dir_o(cyc_dir), .cyc_nxt_o(cyc_nxt),
    .pos_o(pos), .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic set_cyc(input logic [2:0] v);
    set_val = v; set_stb = 1'b1; #1; set_stb = 1'b0;
  endtask

  // Issues one request and records what the DUT did, cycle numbers relative to accept.
  task automatic do_move(input logic [2:0] tgt, output int done_cyc, output int pulses,
                         output int first_rise, output int err_cyc, output bit duty_ok,
                         output bit busy_ok, output logic dir_seen, output logic [11:0] seq,
                         output logic ready_after);
    int hi, lo;
    logic prev;
    done_cyc = -1; pulses = 0; first_rise = -1; err_cyc = -1;
    duty_ok = 1'b1; busy_ok = 1'b1; dir_seen = 1'bx; seq = '0;
    hi = 0; lo = 0; prev = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_target = tgt;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (err && err_cyc < 0) err_cyc = c;
      if (cyc_nxt && !prev) begin
        if (pulses > 0 && lo != 4) duty_ok = 1'b0;
        pulses++;
        if (first_rise < 0) first_rise = c;
        seq = {seq[8:0], cyc_num};
        hi = 0;
      end
      if (!cyc_nxt && prev) begin
        if (hi != 4) duty_ok = 1'b0;
        lo = 0;
      end
      if (done) begin
        if (pulses > 0 && lo != 4) duty_ok = 1'b0;
        done_cyc = c; dir_seen = cyc_dir;
        break;
      end
      if (cyc_nxt) hi++; else lo++;
      prev = cyc_nxt;
    end
    @(negedge clk); ready_after = req_ready;
  endtask

  task automatic test_reset;
    logic [7:0] got;
    got = {cyc_nxt, cyc_dir, pos, busy, done, err};
    n_cmp++; if (got !== 8'b0) begin n_bad++; $display("FAIL reset_outs got=%b exp=%b", got, 8'b0); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_up;
    int dc, np, fr, ec; bit dok, bok; logic d; logic [11:0] s; logic ra;
    set_cyc(3'd0);
    do_move(3'd3, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (dc !== 28) begin n_bad++; $display("FAIL up_done_cyc got=%0d exp=28", dc); end
    n_cmp++; if (np !== 3) begin n_bad++; $display("FAIL up_pulses got=%0d exp=3", np); end
    n_cmp++; if (fr !== 4) begin n_bad++; $display("FAIL up_first_rise got=%0d exp=4", fr); end
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL up_dir got=%b exp=0", d); end
    n_cmp++; if (s !== {3'd0, 3'd1, 3'd2, 3'd3}) begin n_bad++; $display("FAIL up_seq got=%h exp=%h", s, {3'd0, 3'd1, 3'd2, 3'd3}); end
    n_cmp++; if (!dok) begin n_bad++; $display("FAIL up_duty got=bad exp=4/4"); end
    n_cmp++; if (!bok) begin n_bad++; $display("FAIL up_busy got=drop exp=held"); end
    n_cmp++; if (ec !== -1) begin n_bad++; $display("FAIL up_err got=%0d exp=-1", ec); end
    n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL up_ready_after got=%b exp=1", ra); end
  endtask

  task automatic test_down;
    int dc, np, fr, ec; bit dok, bok; logic d; logic [11:0] s; logic ra;
    set_cyc(3'd1);
    do_move(3'd6, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL down_dir got=%b exp=1", d); end
    n_cmp++; if (np !== 3) begin n_bad++; $display("FAIL down_pulses got=%0d exp=3", np); end
    n_cmp++; if (s !== {3'd0, 3'd0, 3'd7, 3'd6}) begin n_bad++; $display("FAIL down_seq got=%h exp=%h", s, {3'd0, 3'd0, 3'd7, 3'd6}); end
    n_cmp++; if (dc !== 28) begin n_bad++; $display("FAIL down_done_cyc got=%0d exp=28", dc); end
    n_cmp++; if (pos !== 3'd6) begin n_bad++; $display("FAIL down_pos got=%0d exp=6", pos); end
    n_cmp++; if (ec !== -1) begin n_bad++; $display("FAIL down_err got=%0d exp=-1", ec); end
  endtask

  task automatic test_tie_wrap;
    int dc, np, fr, ec; bit dok, bok; logic d; logic [11:0] s; logic ra;
    set_cyc(3'd0);
    do_move(3'd4, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL tie_dir got=%b exp=0", d); end
    n_cmp++; if (np !== 4) begin n_bad++; $display("FAIL tie_pulses got=%0d exp=4", np); end
    n_cmp++; if (dc !== 36) begin n_bad++; $display("FAIL tie_done_cyc got=%0d exp=36", dc); end
    n_cmp++; if (!dok) begin n_bad++; $display("FAIL tie_duty got=bad exp=4/4"); end
    set_cyc(3'd6);
    do_move(3'd1, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (s !== {3'd0, 3'd7, 3'd0, 3'd1}) begin n_bad++; $display("FAIL wrap_seq got=%h exp=%h", s, {3'd0, 3'd7, 3'd0, 3'd1}); end
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL wrap_dir got=%b exp=0", d); end
    n_cmp++; if (dc !== 28) begin n_bad++; $display("FAIL wrap_done_cyc got=%0d exp=28", dc); end
  endtask

  task automatic test_zero_dist;
    int dc, np, fr, ec; bit dok, bok; logic d; logic [11:0] s; logic ra;
    set_cyc(3'd5);
    do_move(3'd5, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL zero_done_cyc got=%0d exp=2", dc); end
    n_cmp++; if (np !== 0) begin n_bad++; $display("FAIL zero_pulses got=%0d exp=0", np); end
    n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL zero_ready_after got=%b exp=1", ra); end
  endtask

  task automatic test_back_to_back;
    int acc, dn;
    bit drop;
    acc = 0; dn = 0; drop = 1'b0;
    set_cyc(3'd5);
    @(negedge clk); req_valid = 1'b1; req_target = 3'd2;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (drop) begin req_valid = 1'b0; drop = 1'b0; end
      if (done) dn++;
      if (req_ready && req_valid) begin
        acc++;
        if (acc == 2) drop = 1'b1;
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
    n_cmp++; if (dn !== 2) begin n_bad++; $display("FAIL b2b_dones got=%0d exp=2", dn); end
    n_cmp++; if (pos !== 3'd2) begin n_bad++; $display("FAIL b2b_pos got=%0d exp=2", pos); end
  endtask

  task automatic test_mismatch;
    int dc, np, fr, ec; bit dok, bok; logic d; logic [11:0] s; logic ra;
    hold_val = 3'd2; hold = 1'b1;
    do_move(3'd4, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (ec !== 12) begin n_bad++; $display("FAIL mis_err_cyc got=%0d exp=12", ec); end
    n_cmp++; if (np !== 2) begin n_bad++; $display("FAIL mis_pulses got=%0d exp=2", np); end
    n_cmp++; if (dc !== 20) begin n_bad++; $display("FAIL mis_done_cyc got=%0d exp=20", dc); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mis_sticky got=%b exp=1", err); end
    hold = 1'b0;
    set_cyc(3'd4);
    do_move(3'd4, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (ec !== -1) begin n_bad++; $display("FAIL mis_clear_cyc got=%0d exp=-1", ec); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mis_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid;
    int rises, dn, dc, np, fr, ec; bit dok, bok; logic d; logic [11:0] s; logic ra;
    logic prev;
    rises = 0; dn = 0; prev = 1'b0;
    set_cyc(3'd0);
    @(negedge clk); req_valid = 1'b1; req_target = 3'd3;
    @(posedge clk);
    for (int c = 1; c <= 40 && rises < 2; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (cyc_nxt && !prev) rises++;
      prev = cyc_nxt;
    end
    n_cmp++; if (rises !== 2) begin n_bad++; $display("FAIL rst_reach_step2 got=%0d exp=2", rises); end
    @(negedge clk);
    rst_n = 1'b0; #1;
    n_cmp++; if ({cyc_nxt, busy, done, req_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid_outs got=%b exp=0001", {cyc_nxt, busy, done, req_ready});
    end
    n_cmp++; if (pos !== 3'd0) begin n_bad++; $display("FAIL rst_mid_pos got=%0d exp=0", pos); end
    repeat (4) begin @(negedge clk); if (done) dn++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done) dn++; end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d exp=0", dn); end
    do_move(3'd5, dc, np, fr, ec, dok, bok, d, s, ra);
    n_cmp++; if (s !== {3'd0, 3'd3, 3'd4, 3'd5}) begin n_bad++; $display("FAIL rst_resume_seq got=%h exp=%h", s, {3'd0, 3'd3, 3'd4, 3'd5}); end
    n_cmp++; if (dc !== 28) begin n_bad++; $display("FAIL rst_resume_done got=%0d exp=28", dc); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_resume_err got=%b exp=0", err); end
  endtask

  initial begin
    set_cyc(3'd0);
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_up;
    test_down;
    test_tie_wrap;
    test_zero_dist;
    test_back_to_back;
    test_mismatch;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cycler_seek_ctrl.md
# cycler_seek_ctrl

Sequencer for the `blind_cycler` up/down counter. It accepts a target value over a valid/ready handshake and reads the cycler's current value at acceptance. It then drives `dir` and `nxt` to walk the cycler to the target by the shortest path around the ring. A shadow position is kept and checked against the cycler's output after every step, and a sticky error is raised on any divergence.

## Interface
- `WIDTH`, 3: width of cycler value and target; ring size is 2^WIDTH.
- `SETUP`, 2: clock cycles `cyc_dir` is held stable before the first `cyc_nxt` rise of a move (≥1).
- `HALF_PERIOD`, 4: clock cycles `cyc_nxt` stays high, then low, per step (≥1).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  target request valid.
- `req_ready`  out  1  controller idle, can accept.
- `req_target`  in  WIDTH  requested cycler value.
- `cyc_num`  in  WIDTH  cycler output value.
- `cyc_dir`  out  1  to cycler `dir`; 0 = count up, 1 = count down.
- `cyc_nxt`  out  1  to cycler `nxt`; the cycler advances on its rising edge.
- `pos`  out  WIDTH  shadow position.
- `busy`  out  1  move in progress (not IDLE).
- `done`  out  1  one-cycle pulse at move completion.
- `err`  out  1  sticky mismatch flag.

## Operation
- States and transitions:
  - IDLE → CALC on accept.
  - CALC → SETUP when distance > 0.
  - CALC → DONE when distance = 0.
  - SETUP → HIGH.
  - HIGH → LOW.
  - LOW → HIGH when remaining > 0.
  - LOW → DONE when remaining = 0.
  - DONE → IDLE.
- `req_ready` = (state == IDLE). Accept = `req_valid & req_ready`.
- On accept: latch `req_target`, load `pos <= cyc_num`, clear `err`.
- Requests presented while not ready are ignored; no queuing.
- CALC distance: `up = (target - pos) mod 2^WIDTH`.
  - If `up <= 2^(WIDTH-1)`: `cyc_dir <= 0`, remaining = `up`. A tie goes up.
  - Else: `cyc_dir <= 1`, remaining = `2^WIDTH - up`.
  - Remaining counter is WIDTH bits wide. Maximum remaining is 2^(WIDTH-1).
- SETUP: `cyc_nxt` = 0 for SETUP cycles with `cyc_dir` stable.
- HIGH: `cyc_nxt` = 1 for HALF_PERIOD cycles.
  - On HIGH entry, update `pos` by ±1 modulo 2^WIDTH, per `cyc_dir`.
  - On HIGH entry, decrement remaining.
- LOW: `cyc_nxt` = 0 for HALF_PERIOD cycles.
  - On the last LOW cycle, compare `cyc_num` with `pos`. If they differ, set `err` (sticky).
  - The move continues regardless of `err`.
- `cyc_dir` changes only in CALC. It holds its value through IDLE between moves.
- Wrap-around: `pos` steps 7→0 (up) and 0→7 (down) for WIDTH=3.

## Timing
- Reset values: `cyc_nxt`=0, `cyc_dir`=0, `pos`=0, `busy`=0, `done`=0, `err`=0, `req_ready`=1, state IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Accept edge = cycle 0; CALC = cycle 1.
- Distance d > 0:
  - First `cyc_nxt` rise at cycle 2+SETUP.
  - Each step takes 2·HALF_PERIOD cycles.
  - `done` is high in cycle 2+SETUP+2·HALF_PERIOD·d.
  - `req_ready` returns the following cycle.
- Distance 0: `done` at cycle 2, no `cyc_nxt` activity.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `cyc_nxt` duty is exactly HALF_PERIOD high / HALF_PERIOD low; there are no glitches or extra pulses.
- Reset asserted mid-move: all outputs return to their reset values immediately.
  - A high `cyc_nxt` falls; this is harmless to the cycler.
  - The move is abandoned, with no `done` pulse.
  - After release, the controller is IDLE and resynchronises `pos` from `cyc_num` on the next accept.

## Test plan
- Defaults, cycler at 0, target 3 → `cyc_dir`=0, 3 `cyc_nxt` pulses of 4 high/4 low, `cyc_num` 1,2,3, `done` at cycle 28, `err`=0.
- Cycler at 1, target 6 → `up`=5 > 4, so `cyc_dir`=1, 3 pulses, `pos` 0,7,6, `done` at cycle 28.
- Cycler at 0, target 4 (tie) → `cyc_dir`=0, 4 pulses, `done` at cycle 36. Also cycler at 6, target 1 → up with wrap, `cyc_num` 7,0,1.
- Target equal to current value (5→5) → no `cyc_nxt` edge, `done` at cycle 2. Also `req_valid` held during a move → not accepted until `req_ready`, then accepted exactly once.
- `cyc_num` forced to a constant 2, request from 2 to 4 → `err`=1 after the first LOW, second step still issued, `done` at cycle 20. `err` clears on the next accept.
- `rst_n` pulled low during the second HIGH of a 3-step move → `cyc_nxt`=0 and `busy`=0 immediately, no `done`. A new request after release completes normally from the current `cyc_num`.
